// File: rtl/mac_operand_sequencer_if.sv
// Host and MAC-side signal bundle for the MAC operand sequencer.
// The slave modport is the sequencer; master is the host/MAC side.
interface mac_operand_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [DATA_W-1:0] mac_data_a;
  logic [DATA_W-1:0] mac_data_b;
  logic              mac_rst_mul;
  logic              mac_start;
  logic              mac_done;
  logic [DATA_W-1:0] mac_sum;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;
  logic              res_err;

  modport slave (
    input  in_valid, in_a, in_b,
    output in_ready,
    output mac_data_a, mac_data_b,
    output mac_rst_mul, mac_start,
    input  mac_done, mac_sum,
    output res_valid, res_data, res_err,
    input  res_ready
  );

  modport master (
    output in_valid, in_a, in_b,
    input  in_ready,
    input  mac_data_a, mac_data_b,
    input  mac_rst_mul, mac_start,
    output mac_done, mac_sum,
    input  res_valid, res_data, res_err,
    output res_ready
  );
endinterface

// File: rtl/mac_operand_sequencer.sv
// Queues operand pairs and issues them to the MAC one at a time.
// Optional WAIT timeout enabled by defining MAC_TIMEOUT_EN.
module mac_operand_sequencer #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 4,
  parameter int MUL_RST_CYC = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  mac_operand_sequencer_if.slave   bus,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW =
    (MUL_RST_CYC > 1) ? $clog2(MUL_RST_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE, PREP, START, WAIT
  } state_e;

  state_e state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;

  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;

  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic rst_mul_q, start_q, busy_q, rv_q;

  logic full, push, pop;
  logic done_hit, to_hit, tlim;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign push    = bus.in_valid && !full;
  assign pop     = (state_q == IDLE) &&
                   (cnt_q != '0) && !rv_q;

  assign bus.in_ready    = !full;
  assign pending         = cnt_q;
  assign busy            = busy_q;
  assign bus.mac_data_a  = a_q;
  assign bus.mac_data_b  = b_q;
  assign bus.mac_rst_mul = rst_mul_q;
  assign bus.mac_start   = start_q;
  assign bus.res_valid   = rv_q;
  assign bus.res_data    = res_q;

  always_comb begin
    state_d  = state_q;
    rcnt_d   = rcnt_q;
    done_hit = 1'b0;
    to_hit   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = PREP;
          rcnt_d  = '0;
        end
      end
      PREP: begin
        if (rcnt_q == RW'(MUL_RST_CYC-1))
          state_d = START;
        else
          rcnt_d = rcnt_q + RW'(1);
      end
      START: state_d = WAIT;
      WAIT: begin
        if (bus.mac_done) begin
          done_hit = 1'b1;
          state_d  = IDLE;
        end else if (tlim) begin
          to_hit  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= {bus.in_a, bus.in_b};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      rcnt_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      res_q     <= '0;
      rst_mul_q <= 1'b0;
      start_q   <= 1'b0;
      busy_q    <= 1'b0;
      rv_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rcnt_q    <= rcnt_d;
      rst_mul_q <= (state_d == PREP);
      start_q   <= (state_d == START);
      busy_q    <= (state_d != IDLE);
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop) begin
        rptr_q <= rptr_q + AW'(1);
        {a_q, b_q} <= mem_q[rptr_q];
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
        default: ;
      endcase
      if (done_hit) begin
        rv_q  <= 1'b1;
        res_q <= bus.mac_sum;
      end else if (to_hit) begin
        rv_q  <= 1'b1;
        res_q <= '0;
      end else if (rv_q && bus.res_ready) begin
        rv_q  <= 1'b0;
      end
    end
  end

`ifdef MAC_TIMEOUT_EN
  localparam int TW =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0] tcnt_q;
  logic err_q;

  assign tlim        = (tcnt_q == TW'(TIMEOUT-1));
  assign bus.res_err = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tcnt_q <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state_q == WAIT) tcnt_q <= tcnt_q + TW'(1);
      else                 tcnt_q <= '0;
      if (done_hit)    err_q <= 1'b0;
      else if (to_hit) err_q <= 1'b1;
    end
  end
`else
  assign tlim        = 1'b0;
  assign bus.res_err = 1'b0;
`endif

endmodule
